// File: rtl/delay_timer.sv
// Programmable delay/tick generator: periodic or one-shot counter with a
// runtime-loadable period, end-of-period rdy pulse and mid-period half pulse.
module delay_timer #(
    parameter int WIDTH     = 16,
    parameter int CLK_COUNT = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    output logic             rdy,
    output logic             half,
    output logic             busy,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] RESET_PERIOD = WIDTH'(CLK_COUNT);
    localparam logic [WIDTH-1:0] ONE          = WIDTH'(1);

    logic [WIDTH-1:0] period_reg, period_next;
    logic [WIDTH-1:0] cnt_reg,    cnt_next;
    logic             run_reg,    run_next;
    logic             rdy_reg,    rdy_next;
    logic             half_reg,   half_next;

    logic active;
    logic terminal;
    logic mid_point;

    always_comb begin
        active    = en && (!mode || run_reg);
        terminal  = (cnt_reg == period_reg - ONE);
        // Periods below 2 have no meaningful mid-point, so half stays quiet.
        mid_point = (period_reg > ONE) && (cnt_reg == (period_reg >> 1) - ONE);

        period_next = period_reg;
        cnt_next    = cnt_reg;
        run_next    = run_reg;
        rdy_next    = 1'b0;
        half_next   = 1'b0;

        if (load) begin
            period_next = (load_val == '0) ? ONE : load_val;
            cnt_next    = '0;
        end else if (active) begin
            if (terminal) begin
                cnt_next = '0;
                rdy_next = 1'b1;
                if (mode) begin
                    run_next = 1'b0;
                end
            end else begin
                cnt_next  = cnt_reg + ONE;
                half_next = mid_point;
            end
        end

        // A one-shot (re)start overrides the count but keeps a completed
        // period's rdy pulse when it lands on the terminal edge.
        if (mode && start) begin
            run_next  = 1'b1;
            cnt_next  = '0;
            half_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            period_reg <= RESET_PERIOD;
            cnt_reg    <= '0;
            run_reg    <= 1'b0;
            rdy_reg    <= 1'b0;
            half_reg   <= 1'b0;
        end else begin
            period_reg <= period_next;
            cnt_reg    <= cnt_next;
            run_reg    <= run_next;
            rdy_reg    <= rdy_next;
            half_reg   <= half_next;
        end
    end

    assign rdy   = rdy_reg;
    assign half  = half_reg;
    assign busy  = mode ? run_reg : en;
    assign count = cnt_reg;

endmodule

// File: tb/tb_delay_timer.sv
// Directed self-checking bench for delay_timer (WIDTH=16, CLK_COUNT=10).
module tb_delay_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        mode;
    logic        load;
    logic [15:0] load_val;
    logic        start;
    logic        rdy;
    logic        half;
    logic        busy;
    logic [15:0] count;

    int checks = 0;
    int errors = 0;

    delay_timer #(.WIDTH(16), .CLK_COUNT(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .rdy      (rdy),
        .half     (half),
        .busy     (busy),
        .count    (count)
    );

    always #5 clk = ~clk;

    // Outputs are read 1 time unit after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; mode = 1'b0; load = 1'b0; load_val = '0; start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++;
        if (rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b want 0", rdy); end
        checks++;
        if (half !== 1'b0) begin errors++; $display("FAIL reset_half: got %b want 0", half); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
        $display("test_reset done");
    endtask

    // Period 10 from reset: rdy on every 10th edge, half 5 edges after rdy.
    task automatic test_divider;
        for (int i = 1; i <= 200; i++) begin
            tick();
            checks++;
            if (rdy !== ((i % 10) == 0)) begin errors++; $display("FAIL divider_rdy edge %0d: got %b want %b", i, rdy, (i % 10) == 0); end
            checks++;
            if (half !== ((i % 10) == 5)) begin errors++; $display("FAIL divider_half edge %0d: got %b want %b", i, half, (i % 10) == 5); end
            checks++;
            if (count !== 16'(i % 10)) begin errors++; $display("FAIL divider_count edge %0d: got %0d want %0d", i, count, i % 10); end
        end
        $display("test_divider done");
    endtask

    task automatic test_enable;
        for (int i = 0; i < 3; i++) tick();
        en = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++;
            if (count !== 16'd3) begin errors++; $display("FAIL enable_hold_count %0d: got %0d want 3", i, count); end
            checks++;
            if (rdy !== 1'b0 || half !== 1'b0) begin errors++; $display("FAIL enable_hold_pulses %0d: got rdy=%b half=%b want 0 0", i, rdy, half); end
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL enable_hold_busy %0d: got %b want 0", i, busy); end
        end
        en = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            tick();
            checks++;
            if (rdy !== (j == 7)) begin errors++; $display("FAIL enable_resume_rdy %0d: got %b want %b", j, rdy, j == 7); end
            checks++;
            if (half !== (j == 2)) begin errors++; $display("FAIL enable_resume_half %0d: got %b want %b", j, half, j == 2); end
        end
        $display("test_enable done");
    endtask

    task automatic test_load;
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (count !== 16'd8) begin errors++; $display("FAIL load_pre_count: got %0d want 8", count); end
        load = 1'b1; load_val = 16'd4;
        tick();
        load = 1'b0;
        checks++;
        if (count !== 16'd0 || rdy !== 1'b0) begin errors++; $display("FAIL load4_apply: got count=%0d rdy=%b want 0 0", count, rdy); end
        for (int j = 1; j <= 12; j++) begin
            tick();
            checks++;
            if (rdy !== ((j % 4) == 0)) begin errors++; $display("FAIL load4_rdy %0d: got %b want %b", j, rdy, (j % 4) == 0); end
            checks++;
            if (half !== ((j % 4) == 2)) begin errors++; $display("FAIL load4_half %0d: got %b want %b", j, half, (j % 4) == 2); end
        end
        load = 1'b1; load_val = 16'd0;
        tick();
        load = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            tick();
            checks++;
            if (rdy !== 1'b1 || half !== 1'b0 || count !== 16'd0) begin
                errors++; $display("FAIL load0_period1 %0d: got rdy=%b half=%b count=%0d want 1 0 0", j, rdy, half, count);
            end
        end
        load = 1'b1; load_val = 16'd3;
        tick();
        load = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            tick();
            checks++;
            if (rdy !== ((j % 3) == 0)) begin errors++; $display("FAIL load3_rdy %0d: got %b want %b", j, rdy, (j % 3) == 0); end
            checks++;
            if (half !== ((j % 3) == 1)) begin errors++; $display("FAIL load3_half %0d: got %b want %b", j, half, (j % 3) == 1); end
        end
        $display("test_load done");
    endtask

    task automatic test_oneshot;
        load = 1'b1; load_val = 16'd6; mode = 1'b1;
        tick();
        load = 1'b0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || count !== 16'd0 || rdy !== 1'b0) begin
            errors++; $display("FAIL oneshot_idle: got busy=%b count=%0d rdy=%b want 0 0 0", busy, count, rdy);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || count !== 16'd0) begin errors++; $display("FAIL oneshot_start: got busy=%b count=%0d want 1 0", busy, count); end
        for (int j = 1; j <= 6; j++) begin
            tick();
            checks++;
            if (rdy !== (j == 6)) begin errors++; $display("FAIL oneshot_rdy %0d: got %b want %b", j, rdy, j == 6); end
            checks++;
            if (half !== (j == 3)) begin errors++; $display("FAIL oneshot_half %0d: got %b want %b", j, half, j == 3); end
            checks++;
            if (busy !== (j != 6)) begin errors++; $display("FAIL oneshot_busy %0d: got %b want %b", j, busy, j != 6); end
            checks++;
            if (count !== 16'(j % 6)) begin errors++; $display("FAIL oneshot_count %0d: got %0d want %0d", j, count, j % 6); end
        end
        for (int j = 1; j <= 50; j++) begin
            tick();
            checks++;
            if (rdy !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL oneshot_quiet %0d: got rdy=%b busy=%b want 0 0", j, rdy, busy); end
        end
        $display("test_oneshot done");
    endtask

    task automatic test_retrigger;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 1; j <= 3; j++) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (count !== 16'd0 || rdy !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL retrig_restart: got count=%0d rdy=%b busy=%b want 0 0 1", count, rdy, busy);
        end
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (rdy !== (k == 6)) begin errors++; $display("FAIL retrig_rdy %0d: got %b want %b", k, rdy, k == 6); end
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL retrig_done_busy: got %b want 0", busy); end
        // Restart exactly on the terminal edge.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 1; j <= 5; j++) tick();
        checks++;
        if (count !== 16'd5) begin errors++; $display("FAIL term_pre_count: got %0d want 5", count); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (rdy !== 1'b1 || busy !== 1'b1 || count !== 16'd0) begin
            errors++; $display("FAIL term_restart: got rdy=%b busy=%b count=%0d want 1 1 0", rdy, busy, count);
        end
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (rdy !== (k == 6)) begin errors++; $display("FAIL term_rdy %0d: got %b want %b", k, rdy, k == 6); end
            checks++;
            if (busy !== (k != 6)) begin errors++; $display("FAIL term_busy %0d: got %b want %b", k, busy, k != 6); end
        end
        $display("test_retrigger done");
    endtask

    task automatic test_reset_mid;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 1; j <= 3; j++) tick();
        checks++;
        if (count !== 16'd3) begin errors++; $display("FAIL rstmid_pre_count: got %0d want 3", count); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (rdy !== 1'b0 || half !== 1'b0 || busy !== 1'b0 || count !== 16'd0) begin
            errors++; $display("FAIL rstmid_state: got rdy=%b half=%b busy=%b count=%0d want 0 0 0 0", rdy, half, busy, count);
        end
        mode = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            checks++;
            if (rdy !== ((i % 10) == 0)) begin errors++; $display("FAIL rstmid_period_rdy %0d: got %b want %b", i, rdy, (i % 10) == 0); end
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_divider();
        test_enable();
        test_load();
        test_oneshot();
        test_retrigger();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
